// File: rtl/ulpi_tx_arbiter.sv
// ulpi_tx_arbiter: round-robin owner of the ULPI transmit path for three link-side requesters
//   Source 0 sends a handshake token, source 1 a data packet and source 2 a PHY register write.
//   The granted source is run through TXCMD, data bytes and stp.
//   The block backs off whenever the PHY turns the bus around (dir high).
// Ports:
//   clk, n_rst                      clock, asynchronous active-low reset
//   i_ulpi_tick                     one-clk strobe per ULPI clock edge; state only advances on it
//   i_dir, i_nxt                    ULPI direction / next from the PHY
//   o_ulpi_data_out, o_ulpi_oe      byte to the PHY and its bus enable
//   o_stp                           ULPI stop
//   i_req, o_grant                  per-source request and one-hot grant
//   o_done, o_abort                 one-clk completion / abandon pulses per source
//   i_hs_pid                        source 0 PID
//   i_pkt_pid, i_pkt_byte           source 1 PID and current payload byte
//   i_pkt_last, o_pkt_pop           source 1 last-byte flag and byte-consumed pulse
//   i_reg_addr, i_reg_data          source 2 register address and write data
module ulpi_tx_arbiter (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       i_ulpi_tick,
    input  logic       i_dir,
    input  logic       i_nxt,
    output logic [7:0] o_ulpi_data_out,
    output logic       o_ulpi_oe,
    output logic       o_stp,
    input  logic [2:0] i_req,
    output logic [2:0] o_grant,
    output logic [2:0] o_done,
    output logic [2:0] o_abort,
    input  logic [3:0] i_hs_pid,
    input  logic [3:0] i_pkt_pid,
    input  logic [7:0] i_pkt_byte,
    input  logic       i_pkt_last,
    output logic       o_pkt_pop,
    input  logic [5:0] i_reg_addr,
    input  logic [7:0] i_reg_data
);
    typedef enum logic [2:0] {IDLE, CMD, DATA, STOP, TURN} state_t;
    state_t     r_state;
    logic [2:0] r_grant;
    logic [2:0] r_done;
    logic [2:0] r_abort;
    logic       r_pop;
    logic [1:0] r_last;
    logic [7:0] r_wait;
    logic [1:0] w_c1;
    logic [1:0] w_c2;
    logic [1:0] w_win;
    logic [7:0] w_cmd;
    logic [7:0] w_dat;

    // Search order starts at the source after the previous winner and wraps back to it.
    assign w_c1  = (r_last == 2'd2) ? 2'd0 : r_last + 2'd1;
    assign w_c2  = (w_c1 == 2'd2) ? 2'd0 : w_c1 + 2'd1;
    assign w_win = i_req[w_c1] ? w_c1 : i_req[w_c2] ? w_c2 : r_last;

    assign w_cmd = r_grant[0] ? {4'b0100, i_hs_pid} :
                   r_grant[1] ? {4'b0100, i_pkt_pid} : {2'b10, i_reg_addr};
    assign w_dat = r_grant[1] ? i_pkt_byte : i_reg_data;

    assign o_ulpi_data_out = (r_state == CMD) ? w_cmd : (r_state == DATA) ? w_dat : 8'h00;
    assign o_ulpi_oe       = (r_state == CMD) || (r_state == DATA) || (r_state == STOP);
    assign o_stp           = (r_state == STOP);
    assign o_grant         = r_grant;
    assign o_done          = r_done;
    assign o_abort         = r_abort;
    assign o_pkt_pop       = r_pop;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= IDLE;
            r_grant <= 3'b000;
            r_done  <= 3'b000;
            r_abort <= 3'b000;
            r_pop   <= 1'b0;
            r_last  <= 2'd2;
            r_wait  <= 8'd0;
        end else begin
            // Pulses live for exactly one clk after the tick edge that raised them.
            r_done  <= 3'b000;
            r_abort <= 3'b000;
            r_pop   <= 1'b0;
            if (i_ulpi_tick) begin
                case (r_state)
                    IDLE: begin
                        if (i_dir) begin
                            r_state <= TURN;
                        end else if (|i_req) begin
                            r_grant <= 3'b001 << w_win;
                            r_last  <= w_win;
                            r_wait  <= 8'd0;
                            r_state <= CMD;
                        end
                    end
                    CMD: begin
                        if (i_dir) begin
                            r_abort <= r_grant;
                            r_grant <= 3'b000;
                            r_state <= TURN;
                        end else if (i_nxt) begin
                            r_state <= r_grant[0] ? STOP : DATA;
                        end else if (r_wait == 8'd254) begin
                            // 255th tick without nxt: the PHY is not listening, give up.
                            r_abort <= r_grant;
                            r_grant <= 3'b000;
                            r_state <= IDLE;
                        end else begin
                            r_wait <= r_wait + 8'd1;
                        end
                    end
                    DATA: begin
                        if (i_dir) begin
                            r_abort <= r_grant;
                            r_grant <= 3'b000;
                            r_state <= TURN;
                        end else if (i_nxt) begin
                            r_pop <= r_grant[1];
                            if (r_grant[2] || i_pkt_last)
                                r_state <= STOP;
                        end
                    end
                    STOP: begin
                        r_done  <= r_grant;
                        r_grant <= 3'b000;
                        r_state <= i_dir ? TURN : IDLE;
                    end
                    TURN: begin
                        // The tick that sees dir low is the turnaround cycle itself; arbitrate on the next one.
                        if (!i_dir)
                            r_state <= IDLE;
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ulpi_tx_arbiter.sv
// tb_ulpi_tx_arbiter: ulpi_tx_arbiter against a transfer-queue reference model, with directed and random stimulus
//   Each granted transfer is modelled as a queue of expected bus beats {stp, data}.
//   Beats are consumed on nxt, and the stop beat is consumed on the next tick.
//   Ports: none (top-level bench).
module tb_ulpi_tx_arbiter;
    logic       clk = 0;
    logic       n_rst = 0;
    logic       tick = 0;
    logic       dir = 0;
    logic       nxt = 0;
    logic [2:0] req = 0;
    logic [3:0] hs_pid = 0;
    logic [3:0] pkt_pid = 0;
    logic [7:0] pkt_byte = 0;
    logic       pkt_last = 0;
    logic [5:0] reg_addr = 0;
    logic [7:0] reg_data = 0;
    logic [7:0] o_data;
    logic       o_oe;
    logic       o_stp;
    logic [2:0] o_grant;
    logic [2:0] o_done;
    logic [2:0] o_abort;
    logic       o_pop;

    ulpi_tx_arbiter dut (
        .clk(clk), .n_rst(n_rst), .i_ulpi_tick(tick), .i_dir(dir), .i_nxt(nxt),
        .o_ulpi_data_out(o_data), .o_ulpi_oe(o_oe), .o_stp(o_stp),
        .i_req(req), .o_grant(o_grant), .o_done(o_done), .o_abort(o_abort),
        .i_hs_pid(hs_pid), .i_pkt_pid(pkt_pid), .i_pkt_byte(pkt_byte), .i_pkt_last(pkt_last),
        .o_pkt_pop(o_pop), .i_reg_addr(reg_addr), .i_reg_data(reg_data)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] pkt_arr [0:7];
    int         pkt_len = 1;
    int         pi = 0;
    int         pops = 0;
    int         dones = 0;
    logic [2:0] want = 0;
    bit         rnd = 0;
    logic [2:0] prev_g = 0;
    logic [2:0] gseq [$];
    bit         tk_now = 0;
    bit         tk_prev = 0;
    bit         rd = 0;

    // Inputs as seen by the DUT at the next rising edge.
    logic       s_tick = 0;
    logic       s_dir = 0;
    logic       s_nxt = 0;
    logic [2:0] s_req = 0;

    // Reference model: owner (-1 none), pending bus beats, turnaround flag, round-robin pointer.
    int         m_own = -1;
    bit         m_turn = 0;
    int         m_last = 2;
    int         m_wait = 0;
    int         m_sent = 0;
    logic [8:0] q [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic build_q();
        q.delete();
        if (m_own == 0) begin
            q.push_back({1'b0, 4'b0100, hs_pid});
        end else if (m_own == 1) begin
            q.push_back({1'b0, 4'b0100, pkt_pid});
            for (int k = 0; k < pkt_len; k++) q.push_back({1'b0, pkt_arr[k]});
        end else begin
            q.push_back({1'b0, 2'b10, reg_addr});
            q.push_back({1'b0, reg_data});
        end
        q.push_back(9'h100);
    endtask

    task automatic new_payload(input int s);
        if (s == 0) hs_pid = 4'($urandom);
        if (s == 1) begin
            pkt_pid = 4'($urandom);
            pkt_len = $urandom_range(1, 6);
            for (int k = 0; k < 8; k++) pkt_arr[k] = 8'($urandom);
        end
        if (s == 2) begin
            reg_addr = 6'($urandom);
            reg_data = 8'($urandom);
        end
    endtask

    // One clk: advance the model by the edge just taken, check, react as the sources, drive next inputs.
    task automatic cycle(input logic t, input logic d, input logic n);
        logic [2:0] e_done;
        logic [2:0] e_abort;
        logic       e_pop;
        logic [8:0] e_bus;
        logic [2:0] e_g;
        @(negedge clk);
        e_done = 0;
        e_abort = 0;
        e_pop = 0;
        if (s_tick) begin
            if (m_own < 0) begin
                if (m_turn) m_turn = s_dir;
                else if (s_dir) m_turn = 1;
                else if (s_req != 0) begin
                    for (int k = 1; k <= 3; k++)
                        if (m_own < 0 && s_req[(m_last + k) % 3]) m_own = (m_last + k) % 3;
                    m_last = m_own;
                    m_wait = 0;
                    m_sent = 0;
                    build_q();
                end
            end else if (q[0][8]) begin
                e_done[m_own] = 1;
                m_own = -1;
                m_turn = s_dir;
            end else if (s_dir) begin
                e_abort[m_own] = 1;
                m_own = -1;
                m_turn = 1;
            end else if (s_nxt) begin
                e_pop = (m_own == 1) && (m_sent > 0);
                void'(q.pop_front());
                m_sent++;
            end else if (m_sent == 0) begin
                m_wait++;
                if (m_wait == 255) begin
                    e_abort[m_own] = 1;
                    m_own = -1;
                end
            end
        end
        chk("done", o_done, e_done);
        chk("abort", o_abort, e_abort);
        chk("pkt_pop", o_pop, e_pop);
        if (o_pop) begin
            pops++;
            if (pi < pkt_len - 1) pi++;
        end
        if (o_done[1]) dones++;
        for (int s = 0; s < 3; s++) begin
            if (o_done[s] || o_abort[s]) begin
                req[s] = 0;
                if (s == 1) pi = 0;
            end
            if (want[s] && !req[s]) begin
                if (rnd) new_payload(s);
                if (s == 1) pi = 0;
                req[s] = 1;
            end
        end
        tick = t;
        dir = d;
        nxt = n;
        pkt_byte = pkt_arr[pi];
        pkt_last = (pi == pkt_len - 1);
        s_tick = t;
        s_dir = d;
        s_nxt = n;
        s_req = req;
        #1;
        e_bus = (m_own >= 0) ? q[0] : 9'h000;
        e_g = (m_own >= 0) ? 3'(1 << m_own) : 3'b000;
        chk("oe", o_oe, m_own >= 0);
        chk("stp", o_stp, e_bus[8]);
        chk("data", o_data, e_bus[7:0]);
        chk("grant", o_grant, e_g);
        if (prev_g == 0 && o_grant != 0) gseq.push_back(o_grant);
        prev_g = o_grant;
    endtask

    task automatic tk(input logic d, input logic n);
        cycle(1, d, n);
        cycle(0, d, n);
    endtask

    task automatic do_reset();
        @(negedge clk);
        n_rst = 0;
        tick = 0;
        s_tick = 0;
        req = 0;
        want = 0;
        pi = 0;
        m_own = -1;
        m_turn = 0;
        m_last = 2;
        q.delete();
        #1;
        chk("rst_oe", o_oe, 0);
        chk("rst_data", o_data, 0);
        chk("rst_stp", o_stp, 0);
        chk("rst_grant", o_grant, 0);
        chk("rst_done", o_done, 0);
        chk("rst_abort", o_abort, 0);
        chk("rst_pop", o_pop, 0);
        repeat (2) @(negedge clk);
        n_rst = 1;
    endtask

    initial begin
        for (int k = 0; k < 8; k++) pkt_arr[k] = 0;

        // Register write
        do_reset();
        reg_addr = 6'h0A;
        reg_data = 8'h55;
        want = 3'b100;
        tk(0, 0);
        want = 0;
        chk("t1_cmd", o_data, 8'h8A);
        chk("t1_grant", o_grant, 3'b100);
        tk(0, 1);
        chk("t1_data", o_data, 8'h55);
        tk(0, 1);
        chk("t1_stp", {o_stp, o_data}, 9'h100);
        tk(0, 0);
        chk("t1_done", o_done, 3'b100);
        chk("t1_grant0", o_grant, 0);

        // Packet
        do_reset();
        pkt_pid = 4'h3;
        pkt_arr[0] = 8'h11;
        pkt_arr[1] = 8'h22;
        pkt_arr[2] = 8'h33;
        pkt_len = 3;
        pops = 0;
        dones = 0;
        want = 3'b010;
        tk(0, 1);
        want = 0;
        chk("t2_cmd", o_data, 8'h43);
        tk(0, 1);
        chk("t2_b0", o_data, 8'h11);
        tk(0, 1);
        chk("t2_b1", o_data, 8'h22);
        tk(0, 1);
        chk("t2_b2", o_data, 8'h33);
        tk(0, 1);
        chk("t2_stp", o_stp, 1);
        tk(0, 1);
        chk("t2_pops", pops, 3);
        chk("t2_dones", dones, 1);

        // Round-robin
        do_reset();
        hs_pid = 4'h2;
        pkt_len = 1;
        gseq.delete();
        want = 3'b111;
        tk(0, 1);
        chk("t3_hs", o_data, 8'h42);
        tk(0, 1);
        chk("t3_hs_stp", o_stp, 1);
        repeat (16) tk(0, 1);
        chk("t3_count", gseq.size() >= 4, 1);
        if (gseq.size() >= 4) begin
            chk("t3_g0", gseq[0], 3'b001);
            chk("t3_g1", gseq[1], 3'b010);
            chk("t3_g2", gseq[2], 3'b100);
            chk("t3_g3", gseq[3], 3'b001);
        end

        // PHY takeover
        do_reset();
        pkt_len = 3;
        want = 3'b010;
        tk(0, 1);
        tk(0, 1);
        tk(0, 1);
        chk("t4_in_data", o_data, 8'h22);
        tk(1, 1);
        chk("t4_abort", o_abort, 3'b010);
        chk("t4_oe", o_oe, 0);
        chk("t4_stp", o_stp, 0);
        tk(1, 0);
        chk("t4_turn_g", o_grant, 0);
        tk(0, 0);
        chk("t4_turnaround_g", o_grant, 0);
        tk(0, 0);
        chk("t4_regrant", o_grant, 3'b010);

        // Timeout
        do_reset();
        want = 3'b001;
        tk(0, 0);
        chk("t5_grant", o_grant, 3'b001);
        repeat (254) tk(0, 0);
        chk("t5_still", o_grant, 3'b001);
        tk(0, 0);
        chk("t5_abort", o_abort, 3'b001);
        chk("t5_idle", o_grant, 0);
        tk(0, 0);
        chk("t5_regrant", o_grant, 3'b001);

        // Reset mid-operation, then source 0 wins first
        do_reset();
        want = 3'b010;
        tk(0, 1);
        tk(0, 1);
        chk("t6_in_data", o_oe, 1);
        do_reset();
        want = 3'b111;
        tk(0, 0);
        chk("t6_first", o_grant, 3'b001);

        // Random traffic
        do_reset();
        rnd = 1;
        for (int c = 0; c < 3000; c++) begin
            if (c % 25 == 0) want = 3'($urandom);
            if (c == 1500) do_reset();
            tk_now = !tk_prev && ($urandom_range(0, 1) == 1);
            if (tk_now) rd = rd ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 15) == 0);
            cycle(tk_now, rd, $urandom_range(0, 3) != 0);
            tk_prev = tk_now;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ulpi_tx_arbiter.md
# ulpi_tx_arbiter

Arbitrates the single ULPI transmit path between three link-side requesters:
- source 0: handshake token
- source 1: data packet stream
- source 2: PHY register write

It sequences the ULPI transmit protocol for the granted requester: TXCMD, data bytes, then `stp`. It backs off when the PHY takes the bus (`dir` high) and reports completion or abort per requester. It sits between the USB protocol state machine's transmit side and the ULPI pins.

## Interface
No parameters.
- `clk`  in  1  system clock
- `n_rst`  in  1  reset, asynchronous, active-low
- `ulpi_tick`  in  1  one-`clk` strobe marking each ULPI clock rising edge; all bus sampling and state advance happen only in tick cycles
- `dir`  in  1  ULPI direction; 1 = PHY owns bus
- `nxt`  in  1  ULPI next; PHY accepts the current byte
- `ulpi_data_out`  out  8  byte driven to PHY
- `ulpi_oe`  out  1  link drives data bus
- `stp`  out  1  ULPI stop
- `req`  in  3  per-source request; must be held until `done`/`abort`
- `grant`  out  3  one-hot grant, held for the whole transfer
- `done`  out  3  one-`clk` pulse: transfer completed
- `abort`  out  3  one-`clk` pulse: transfer abandoned, source must re-request
- `hs_pid`  in  4  source 0 PID
- `pkt_pid`  in  4  source 1 PID
- `pkt_byte`  in  8  source 1 current payload byte
- `pkt_last`  in  1  `pkt_byte` is the final byte
- `pkt_pop`  out  1  one-`clk` pulse: `pkt_byte` consumed, present next byte next `clk`
- `reg_addr`  in  6  source 2 register address
- `reg_data`  in  8  source 2 write data

## Operation
States: IDLE, CMD, DATA, STOP, TURN. All transitions occur only on `clk` edges where `ulpi_tick`=1, except `done`/`abort`/`pkt_pop` pulse timing (see Timing).

- **IDLE:** `oe`=0, `data_out`=0.
  - `dir`=1 → TURN.
  - Else if any `req`: pick winner round-robin, starting from the source after `last_grant`. Register `grant`, update `last_grant`, clear the wait counter, go to CMD.
- **CMD:** `oe`=1. `data_out`:
  - src0: {4'b0100, `hs_pid`}
  - src1: {4'b0100, `pkt_pid`}
  - src2: {2'b10, `reg_addr`}

  Exits (evaluated in this priority):
  - `dir`=1 → abort, TURN.
  - `nxt`=1 → src0 to STOP; src1/src2 to DATA.
  - Otherwise increment the 8-bit wait counter. Reaching 255 ticks without `nxt` → abort, IDLE.
- **DATA:** `oe`=1. `data_out` = `pkt_byte` (src1) or `reg_data` (src2).
  - `dir`=1 → abort, TURN.
  - src1, `nxt`=1: pulse `pkt_pop`. If `pkt_last` → STOP, else stay in DATA.
  - src2, `nxt`=1 → STOP.
  - `nxt`=0: hold the byte and stay; the wait counter is not used in DATA.
- **STOP:** `oe`=1, `stp`=1, `data_out`=0 for exactly one tick. Then pulse `done[grant]`, clear `grant`, go to IDLE. If `dir` is high at that tick, go to TURN instead; `done` still pulses.
- **TURN:** `oe`=0, `grant`=0. Leave for IDLE at the first tick with `dir`=0. That tick is the turnaround cycle, so arbitration is not performed in it.
- **Abort:** pulse `abort[grant]` and clear `grant` in the same transition.
- **Requests:** withdrawal of `req` mid-transfer is ignored.

## Timing
- **Reset values:**
  - state IDLE, `grant` 0, `last_grant`=2 (so source 0 wins the first contest), wait counter 0
  - `ulpi_data_out` 0, `ulpi_oe` 0, `stp` 0, `done` 0, `abort` 0, `pkt_pop` 0
- **Output timing:**
  - Bus outputs and `grant` are decoded from registered state and are stable between ticks.
  - `done`, `abort` and `pkt_pop` are high for the single `clk` following the tick edge that causes them.
- **Latency:** `req` seen at tick N → TXCMD driven from after tick N; earliest first data byte after tick N+1.
- **Handshake token (minimum):** 3 ticks: CMD, STOP, then `done`.
- **Register write (minimum):** 4 ticks.
- **Asynchronous reset mid-transfer:** immediate return to reset values; no `done`/`abort` pulses are generated.
- **`dir` and `nxt` both high in the same tick (CMD or DATA):** `dir` wins → abort.

## Test plan
1. **Register write:** Reset, `req`=3'b100, `reg_addr`=6'h0A, `reg_data`=8'h55, `nxt`=1 on 2nd and 3rd ticks → bus shows 8'h8A, then 8'h55, then `stp`=1 with data 8'h00; `done`=3'b100 pulses; `grant` returns to 0.
2. **Packet:** `req`=3'b010, `pkt_pid`=4'h3, 3 bytes (8'h11, 8'h22, 8'h33 with `pkt_last` on the third), `nxt` always 1 → bus shows 8'h43, 8'h11, 8'h22, 8'h33, then `stp`; exactly 3 `pkt_pop` pulses, 1 `done[1]`.
3. **Round-robin:** `req`=3'b111 held, `hs_pid`=4'h2, `nxt`=1 → grants in order 001, 010, 100, 001; handshake shows 8'h42 then `stp`.
4. **PHY takeover:** `dir` rises during DATA of a packet after 1 byte → `abort[1]` pulses, `oe`=0 the same cycle, no `stp`. TURN holds while `dir`=1. After `dir` falls, arbitration resumes only on the following tick.
5. **Timeout:** src0 request with `nxt` held 0 → after 255 ticks in CMD, `abort[0]` pulses and state returns to IDLE; re-request is granted on the next tick.
6. **Reset mid-operation:** assert `n_rst`=0 in DATA → all outputs 0 immediately. After release, a 3'b111 request grants source 0 first.
